ipf_lcu_feeder: RTL and testbench
=================================

IPF_LCU_FEEDER -- requirements
Module: ipf_lcu_feeder

Interface
REQ-001 SHALL have parameter IMG_W, default 128, meaning image width and height in pixels (fixed 128x128 frame).
REQ-002 SHALL have ports `clk  in  1  sole clock`, rising edge only.
REQ-003 SHALL have ports `reset  in  1`; reset is synchronous and active-high.
REQ-004 SHALL have port `start  in  1`: frame start pulse.
REQ-005 SHALL have port `cfg_lcu_size  in  2`: 0/1/2 selects LCU of 16/32/64 pixels.
REQ-006 SHALL have port `img_rd  out  1`: image memory read strobe.
REQ-007 SHALL have port `img_addr  out  14`: image memory address, row*128+col.
REQ-008 SHALL have port `img_data  in  8`: read data, valid exactly 1 cycle after img_rd.
REQ-009 SHALL have port `busy  in  1`: filter-stage busy flag.
REQ-010 SHALL have ports `in_en  out  1` and `din  out  8`: pixel strobe and pixel value to the filter stage.
REQ-011 SHALL have ports `lcu_x  out  3`, `lcu_y  out  3`, `lcu_size  out  2`: coordinates and size of the current LCU.
REQ-012 SHALL have port `done  out  1`: frame complete, level.

Function
REQ-013 SHALL use N = 16<<lcu_size, LCU count per axis = 8>>lcu_size, raster LCU order: lcu_x fastest, then lcu_y.
REQ-014 SHALL use states IDLE, FETCH, WAIT_HI, WAIT_LO, DONE.
REQ-015 IDLE: on start=1 with cfg_lcu_size!=3, SHALL latch size, clear r/c/lcu_x/lcu_y, and enter FETCH; a start with size 3 SHALL be ignored.
REQ-016 FETCH: each cycle SHALL assert img_rd with img_addr = ((lcu_y*N+r)<<7) + lcu_x*N + c, then advance c, wrapping to r+1 at c=N-1.
REQ-017 SHALL drive in_en=1 and din=img_data exactly one cycle after each img_rd; there are no bubbles inside a row.
REQ-018 Rows 0 and 1 of an LCU SHALL stream back-to-back with no pause; after issuing the last read of row r>=2, the block SHALL enter WAIT_HI.
REQ-019 WAIT_HI SHALL hold img_rd=0 until busy=1, then go to WAIT_LO; WAIT_LO SHALL hold until busy=0.
REQ-020 On leaving WAIT_LO, if r was N-1, the block SHALL advance the LCU (x+1, or x=0 and y+1) and set r=0; otherwise it SHALL continue with row r+1 in FETCH.
REQ-021 Leaving WAIT_LO after the last row of LCU (7>>size, 7>>size) SHALL enter DONE and set done=1.
REQ-022 DONE SHALL hold done=1 until the next start, which SHALL clear done and restart the frame.
REQ-023 start in any state other than IDLE or DONE SHALL be ignored.
REQ-024 lcu_x, lcu_y and lcu_size SHALL be stable whenever in_en=1 and SHALL change only while in_en=0.
REQ-025 busy=1 observed during FETCH SHALL NOT stall the block; this is a protocol violation and the result is don't-care.
REQ-026 Each frame SHALL produce exactly 16384 in_en pulses.

Reset
REQ-027 While reset=1, the block SHALL go to IDLE and drive in_en=0, din=0, img_rd=0, img_addr=0, lcu_x=0, lcu_y=0, lcu_size=0, done=0.
REQ-028 Reset mid-frame SHALL abort the frame without emitting any further in_en pulses; a pending read result SHALL be discarded.

Configuration
REQ-029 With IPF_FEED_STAT_EN defined, the block SHALL add output `pix_cnt  out  15`: in_en pulses sent in the current frame, cleared on start and reset, holding 16384 in DONE.
REQ-030 Without IPF_FEED_STAT_EN, the pix_cnt port and its counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-031 Shared package ipf_pkg SHALL hold the state enum, IMG_W, and the LCU-size encoding constants (16/32/64).
REQ-032 Address arithmetic SHALL sit in one combinational sub-module, ipf_feed_addr_gen, with inputs lcu_x, lcu_y, r, c, size and output a 14-bit address.

Verification
REQ-033 Size 0, memory holding addr[7:0]: the first 48 in_en pulses SHALL be back-to-back with din=0..15, 128..143, 256..271 (low byte); after pulse 48 the block SHALL wait for a busy high/low pair.
REQ-034 Size 2, busy model with 5-cycle pulses: the frame SHALL give 16384 pulses, end at lcu_x=lcu_y=0 with size 2, then set done.
REQ-035 Size 1: lcu_x SHALL count 0..3 then lcu_y SHALL step; the first address of LCU (1,2) SHALL be 8224.
REQ-036 Hold busy=0 permanently after row 2: the block SHALL stay in WAIT_HI with img_rd=0 and in_en=0 indefinitely.
REQ-037 Assert reset at pulse 1000, then start with size 0: all outputs SHALL be zero for the reset cycle, and the next frame SHALL begin at img_addr=0.
REQ-038 start with cfg_lcu_size=3, then start mid-frame: both SHALL be ignored; with IPF_FEED_STAT_EN, pix_cnt SHALL end at 16384.

Source files
------------

// File: rtl/ipf_pkg.sv
// Shared definitions for the in-loop-filter LCU feeder: frame geometry,
// LCU size encoding and FSM state encoding.
package ipf_pkg;

    localparam int unsigned IMG_W = 128;

    // cfg_lcu_size encoding
    localparam logic [1:0] LCU_SZ_16  = 2'd0;
    localparam logic [1:0] LCU_SZ_32  = 2'd1;
    localparam logic [1:0] LCU_SZ_64  = 2'd2;
    localparam logic [1:0] LCU_SZ_BAD = 2'd3;

    localparam int unsigned LCU_PIX_16 = 16;
    localparam int unsigned LCU_PIX_32 = 32;
    localparam int unsigned LCU_PIX_64 = 64;

    typedef logic [2:0] ipf_state_t;

    localparam ipf_state_t ST_IDLE    = 3'd0;
    localparam ipf_state_t ST_FETCH   = 3'd1;
    localparam ipf_state_t ST_WAIT_HI = 3'd2;
    localparam ipf_state_t ST_WAIT_LO = 3'd3;
    localparam ipf_state_t ST_DONE    = 3'd4;

    // log2 of the LCU edge length
    function automatic logic [2:0] lcu_shift(input logic [1:0] size);
        return 3'd4 + 3'(size);
    endfunction

    // Last pixel index inside an LCU row/column
    function automatic logic [5:0] lcu_last_pix(input logic [1:0] size);
        case (size)
            LCU_SZ_16: return 6'(LCU_PIX_16 - 1);
            LCU_SZ_32: return 6'(LCU_PIX_32 - 1);
            default:   return 6'(LCU_PIX_64 - 1);
        endcase
    endfunction

    // Last LCU index along one axis of the 128x128 frame
    function automatic logic [2:0] lcu_last_blk(input logic [1:0] size);
        case (size)
            LCU_SZ_16: return 3'd7;
            LCU_SZ_32: return 3'd3;
            default:   return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/ipf_feed_addr_gen.sv
// Combinational image address for pixel (r, c) of LCU (lcu_x, lcu_y):
// ((lcu_y*N + r) * IMG_W) + lcu_x*N + c, with N = 16 << size.
module ipf_feed_addr_gen #(
    parameter  int unsigned IMG_W = ipf_pkg::IMG_W,
    localparam int unsigned AW    = $clog2(IMG_W * IMG_W)
) (
    input  logic [2:0]    lcu_x,
    input  logic [2:0]    lcu_y,
    input  logic [5:0]    r,
    input  logic [5:0]    c,
    input  logic [1:0]    size,
    output logic [AW-1:0] addr
);
    import ipf_pkg::*;

    localparam int unsigned RS = $clog2(IMG_W);

    logic [2:0]    w_sh;
    logic [AW-1:0] w_row_abs;
    logic [AW-1:0] w_col_abs;

    assign w_sh      = lcu_shift(size);
    assign w_row_abs = (AW'(lcu_y) << w_sh) + AW'(r);
    assign w_col_abs = (AW'(lcu_x) << w_sh) + AW'(c);
    assign addr      = (w_row_abs << RS) + w_col_abs;

endmodule

// File: rtl/ipf_lcu_feeder.sv
// Streams a 128x128 frame from image memory to the filter stage LCU by LCU,
// pausing for a busy high/low handshake after every row from row 2 onward.
// Optional pixel counter output enabled by IPF_FEED_STAT_EN.
module ipf_lcu_feeder #(
    parameter  int unsigned IMG_W = 128,
    localparam int unsigned AW    = $clog2(IMG_W * IMG_W)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    cfg_lcu_size,
    output logic          img_rd,
    output logic [AW-1:0] img_addr,
    input  logic [7:0]    img_data,
    input  logic          busy,
    output logic          in_en,
    output logic [7:0]    din,
    output logic [2:0]    lcu_x,
    output logic [2:0]    lcu_y,
    output logic [1:0]    lcu_size,
    output logic          done
`ifdef IPF_FEED_STAT_EN
    ,
    output logic [14:0]   pix_cnt
`endif
);
    import ipf_pkg::*;

    ipf_state_t    r_state;
    logic [5:0]    r_row;
    logic [5:0]    r_col;
    logic [2:0]    r_lcu_x;
    logic [2:0]    r_lcu_y;
    logic [1:0]    r_size;
    logic          r_done;
    logic          r_img_rd;
    logic [AW-1:0] r_img_addr;
    logic          r_in_en;

    ipf_state_t    w_state_nxt;
    logic [5:0]    w_row_nxt;
    logic [5:0]    w_col_nxt;
    logic [2:0]    w_x_nxt;
    logic [2:0]    w_y_nxt;
    logic [1:0]    w_size_nxt;
    logic          w_done_nxt;
    logic          w_issue;
    logic          w_start_ok;
    logic [5:0]    w_last_pix;
    logic [2:0]    w_last_blk;
    logic [AW-1:0] w_addr;

    assign w_start_ok = start && (cfg_lcu_size != LCU_SZ_BAD);
    assign w_last_pix = lcu_last_pix(r_size);
    assign w_last_blk = lcu_last_blk(r_size);

    ipf_feed_addr_gen #(
        .IMG_W (IMG_W)
    ) u_addr_gen (
        .lcu_x (r_lcu_x),
        .lcu_y (r_lcu_y),
        .r     (r_row),
        .c     (r_col),
        .size  (r_size),
        .addr  (w_addr)
    );

    // Next-state, scan counters and LCU stepping
    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_x_nxt     = r_lcu_x;
        w_y_nxt     = r_lcu_y;
        w_size_nxt  = r_size;
        w_done_nxt  = r_done;
        w_issue     = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start_ok) begin
                    w_size_nxt  = cfg_lcu_size;
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                    w_x_nxt     = '0;
                    w_y_nxt     = '0;
                    w_done_nxt  = 1'b0;
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_issue = 1'b1;
                if (r_col == w_last_pix) begin
                    w_col_nxt = '0;
                    // rows 0 and 1 flow straight into the next row
                    if (r_row >= 6'd2) begin
                        w_state_nxt = ST_WAIT_HI;
                    end else begin
                        w_row_nxt = r_row + 6'd1;
                    end
                end else begin
                    w_col_nxt = r_col + 6'd1;
                end
            end
            ST_WAIT_HI: begin
                if (busy) begin
                    w_state_nxt = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (!busy) begin
                    w_state_nxt = ST_FETCH;
                    if (r_row == w_last_pix) begin
                        w_row_nxt = '0;
                        if (r_lcu_x != w_last_blk) begin
                            w_x_nxt = r_lcu_x + 3'd1;
                        end else begin
                            w_x_nxt = '0;
                            if (r_lcu_y != w_last_blk) begin
                                w_y_nxt = r_lcu_y + 3'd1;
                            end else begin
                                w_y_nxt     = '0;
                                w_done_nxt  = 1'b1;
                                w_state_nxt = ST_DONE;
                            end
                        end
                    end else begin
                        w_row_nxt = r_row + 6'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_row      <= '0;
            r_col      <= '0;
            r_lcu_x    <= '0;
            r_lcu_y    <= '0;
            r_size     <= '0;
            r_done     <= 1'b0;
            r_img_rd   <= 1'b0;
            r_img_addr <= '0;
            r_in_en    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_row      <= w_row_nxt;
            r_col      <= w_col_nxt;
            r_lcu_x    <= w_x_nxt;
            r_lcu_y    <= w_y_nxt;
            r_size     <= w_size_nxt;
            r_done     <= w_done_nxt;
            r_img_rd   <= w_issue;
            r_in_en    <= r_img_rd;
            if (w_issue) begin
                r_img_addr <= w_addr;
            end
        end
    end

`ifdef IPF_FEED_STAT_EN
    logic [14:0] r_pix_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pix_cnt <= '0;
        end else if (((r_state == ST_IDLE) || (r_state == ST_DONE)) && w_start_ok) begin
            r_pix_cnt <= '0;
        end else if (r_img_rd) begin
            r_pix_cnt <= r_pix_cnt + 15'd1;
        end
    end

    assign pix_cnt = r_pix_cnt;
`endif

    assign img_rd   = r_img_rd;
    assign img_addr = r_img_addr;
    assign in_en    = r_in_en;
    // Memory data lands the cycle after the read and is forwarded as-is
    assign din      = r_in_en ? img_data : 8'h00;
    assign lcu_x    = r_lcu_x;
    assign lcu_y    = r_lcu_y;
    assign lcu_size = r_size;
    assign done     = r_done;

endmodule

// File: tb/tb_ipf_lcu_feeder.sv
// Directed bench for ipf_lcu_feeder: memory returns addr[7:0], busy model
// answers each row pause with a 5-cycle pulse.
module tb_ipf_lcu_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  cfg_lcu_size;
    logic        img_rd;
    logic [13:0] img_addr;
    logic [7:0]  img_data;
    logic        busy;
    logic        in_en;
    logic [7:0]  din;
    logic [2:0]  lcu_x;
    logic [2:0]  lcu_y;
    logic [1:0]  lcu_size;
    logic        done;
`ifdef IPF_FEED_STAT_EN
    logic [14:0] pix_cnt;
`endif

    int          n_chk;
    int          n_fail;
    int          pulses;
    int          cyc;
    int          cyc_first;
    int          cyc_48;
    int          busy_cnt;
    bit          busy_mode;
    bit          chk_order;
    logic        prev_in_en;
    logic [7:0]  last_din;
    logic [2:0]  prev_x;
    logic [2:0]  prev_y;
    logic [2:0]  last_blk;
    bit          got_12;
    logic [13:0] addr_12;

    always #5 clk = ~clk;

    ipf_lcu_feeder dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cfg_lcu_size (cfg_lcu_size),
        .img_rd       (img_rd),
        .img_addr     (img_addr),
        .img_data     (img_data),
        .busy         (busy),
        .in_en        (in_en),
        .din          (din),
        .lcu_x        (lcu_x),
        .lcu_y        (lcu_y),
        .lcu_size     (lcu_size),
        .done         (done)
`ifdef IPF_FEED_STAT_EN
        ,
        .pix_cnt      (pix_cnt)
`endif
    );

    // Image memory: one-cycle read latency, content = low address byte
    always @(posedge clk) begin
        if (img_rd === 1'b1) img_data <= img_addr[7:0];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_din(input int k);
        int a;
        a = (k / 16) * 128 + (k % 16);
        return 8'(a);
    endfunction

    function automatic logic [5:0] exp_next(input logic [2:0] x, input logic [2:0] y,
                                            input logic [2:0] last);
        if (x != last) return {y, x + 3'd1};
        if (y != last) return {y + 3'd1, 3'd0};
        return 6'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (in_en === 1'b1) begin
            pulses++;
            last_din = din;
            if (pulses == 1) cyc_first = cyc;
            if (pulses == 48) cyc_48 = cyc;
        end
        if (chk_order && ({lcu_y, lcu_x} != {prev_y, prev_x})) begin
            chk("lcu_change_in_en", 32'(in_en), 32'd0);
            chk("lcu_order", 32'({lcu_y, lcu_x}), 32'(exp_next(prev_x, prev_y, last_blk)));
        end
        prev_x = lcu_x;
        prev_y = lcu_y;
        if (img_rd === 1'b1 && lcu_x == 3'd1 && lcu_y == 3'd2 && !got_12) begin
            got_12  = 1'b1;
            addr_12 = img_addr;
        end
        if (busy_mode) begin
            if (prev_in_en === 1'b1 && in_en === 1'b0) busy_cnt = 5;
            busy = (busy_cnt != 0);
            if (busy_cnt > 0) busy_cnt--;
        end
        prev_in_en = in_en;
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_in_en"},    32'(in_en),    32'd0);
        chk({pfx, "_din"},      32'(din),      32'd0);
        chk({pfx, "_img_rd"},   32'(img_rd),   32'd0);
        chk({pfx, "_img_addr"}, 32'(img_addr), 32'd0);
        chk({pfx, "_lcu_x"},    32'(lcu_x),    32'd0);
        chk({pfx, "_lcu_y"},    32'(lcu_y),    32'd0);
        chk({pfx, "_lcu_size"}, 32'(lcu_size), 32'd0);
        chk({pfx, "_done"},     32'(done),     32'd0);
    endtask

    initial begin
        n_chk = 0; n_fail = 0; pulses = 0; cyc = 0; cyc_first = 0; cyc_48 = 0;
        busy_cnt = 0; busy_mode = 1'b0; chk_order = 1'b0; prev_in_en = 1'b0;
        last_din = '0; prev_x = '0; prev_y = '0; last_blk = 3'd7; got_12 = 1'b0; addr_12 = '0;
        reset = 1'b1; start = 1'b0; cfg_lcu_size = 2'd0; busy = 1'b0;

        tick(); tick();
        chk_reset_outputs("rst");
        reset = 1'b0;
        tick();

        // Size 0: rows 0..2 stream back-to-back, then wait for busy
        pulses = 0; cfg_lcu_size = 2'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10 && img_rd !== 1'b1; i++) tick();
        chk("a_first_rd", 32'(img_rd), 32'd1);
        chk("a_first_addr", 32'(img_addr), 32'd0);
        for (int i = 0; i < 300 && pulses < 48; i++) begin
            tick();
            if (in_en === 1'b1) chk("a_din", 32'(din), 32'(exp_din(pulses - 1)));
        end
        chk("a_48_pulses", 32'(pulses), 32'd48);
        chk("a_back_to_back", 32'(cyc_48 - cyc_first), 32'd47);

        // No busy pulse: stays parked
        repeat (100) tick();
        chk("a_stall_pulses", 32'(pulses), 32'd48);
        chk("a_stall_img_rd", 32'(img_rd), 32'd0);
        chk("a_stall_in_en", 32'(in_en), 32'd0);

        busy = 1'b1; tick(); tick();
        busy = 1'b0;
        for (int i = 0; i < 20 && pulses < 49; i++) tick();
        chk("a_row3_din", 32'(last_din), 32'd128);

        busy_mode = 1'b1;
        for (int i = 0; i < 5000 && pulses < 1000; i++) tick();
        chk("a_pulse_1000", 32'(pulses), 32'd1000);

        // Reset mid-frame
        reset = 1'b1; busy_mode = 1'b0; busy = 1'b0; busy_cnt = 0;
        tick();
        chk_reset_outputs("mid_rst");
        reset = 1'b0;
        repeat (3) tick();
        chk("d_no_pulse", 32'(pulses), 32'd1000);

        pulses = 0; cfg_lcu_size = 2'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10 && img_rd !== 1'b1; i++) tick();
        chk("d_restart_rd", 32'(img_rd), 32'd1);
        chk("d_restart_addr", 32'(img_addr), 32'd0);
        for (int i = 0; i < 10 && in_en !== 1'b1; i++) tick();
        chk("d_restart_din", 32'(din), 32'd0);

        reset = 1'b1; tick();
        reset = 1'b0; tick();

        // Size 3 start ignored
        cfg_lcu_size = 2'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("e_sz3_img_rd", 32'(img_rd), 32'd0);
        chk("e_sz3_size", 32'(lcu_size), 32'd0);
        chk("e_sz3_done", 32'(done), 32'd0);

        // Size 1 full frame with mid-frame start ignored
        pulses = 0; cfg_lcu_size = 2'd1; busy_mode = 1'b1; last_blk = 3'd3;
        got_12 = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk_order = 1'b1;
        repeat (50) tick();
        cfg_lcu_size = 2'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("c_size_held", 32'(lcu_size), 32'd1);
        for (int i = 0; i < 60000 && done !== 1'b1; i++) tick();
        chk_order = 1'b0;
        chk("c_done", 32'(done), 32'd1);
        chk("c_pulses", 32'(pulses), 32'd16384);
        chk("c_end_x", 32'(lcu_x), 32'd0);
        chk("c_end_y", 32'(lcu_y), 32'd0);
        chk("c_end_size", 32'(lcu_size), 32'd1);
        chk("c_seen_12", 32'(got_12), 32'd1);
        chk("c_addr_12", 32'(addr_12), 32'd8224);
`ifdef IPF_FEED_STAT_EN
        chk("c_pix_cnt", 32'(pix_cnt), 32'd16384);
`endif
        repeat (5) tick();
        chk("c_done_level", 32'(done), 32'd1);

        // Size 2 frame restarted from DONE
        pulses = 0; cfg_lcu_size = 2'd2; start = 1'b1;
        tick();
        start = 1'b0;
        chk("b_done_clr", 32'(done), 32'd0);
        chk("b_size", 32'(lcu_size), 32'd2);
        for (int i = 0; i < 60000 && done !== 1'b1; i++) tick();
        chk("b_done", 32'(done), 32'd1);
        chk("b_pulses", 32'(pulses), 32'd16384);
        chk("b_end_x", 32'(lcu_x), 32'd0);
        chk("b_end_y", 32'(lcu_y), 32'd0);
        chk("b_end_size", 32'(lcu_size), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
